// File: rtl/leaf_pkg.sv
// ============================================================================
// Module : leaf_pkg
// Desc   : Default sizing constants and output-stage state type for the
//          user port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package leaf_pkg;

  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int DEF_CREDIT_BITS   = 7;
  localparam int DEF_INIT_CREDITS  = 64;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_select.sv
// ============================================================================
// Module : rr_select
// Desc   : Combinational round-robin pick of the first eligible port at or
//          after rr_ptr, wrapping around.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_select #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_BITS  = 1
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PTR_BITS-1:0]  rr_ptr,
  output logic [PTR_BITS-1:0]  grant,
  output logic                 any_eligible
);

  int w_idx;

  // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
  always_comb begin
    grant        = '0;
    any_eligible = |eligible;
    w_idx        = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (eligible[w_idx]) begin
        grant = PTR_BITS'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/user_port_arbiter.sv
// ============================================================================
// Module : user_port_arbiter
// Desc   : Credit-gated round-robin merge of user streams into one registered
//          interface channel.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_port_arbiter
  import leaf_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int CREDIT_BITS   = DEF_CREDIT_BITS,
  parameter int INIT_CREDITS  = DEF_INIT_CREDITS
) (
  input  logic                              clk_user,
  input  logic                              reset,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2arb,
  input  logic [NUM_PORTS-1:0]              vld_user2arb,
  output logic [NUM_PORTS-1:0]              ack_arb2user,
  output logic [PAYLOAD_BITS-1:0]           dout_arb2interface,
  output logic [NUM_PORT_BITS-1:0]          port_arb2interface,
  output logic                              vld_arb2interface,
  input  logic                              ack_interface2arb,
  input  logic                              credit_upd_vld,
  input  logic [NUM_PORT_BITS-1:0]          credit_upd_port,
  input  logic [CREDIT_BITS-1:0]            credit_upd_amt,
  output logic                              credit_ovf_err
);

  localparam int PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CREDIT_BITS-1:0]   c_init       = CREDIT_BITS'(INIT_CREDITS);
  localparam logic [CREDIT_BITS:0]     c_init_ext   = (CREDIT_BITS+1)'(INIT_CREDITS);
  localparam logic [NUM_PORT_BITS-1:0] c_num_ports  = NUM_PORT_BITS'(NUM_PORTS);
  localparam logic [PTR_BITS-1:0]      c_last_port  = PTR_BITS'(NUM_PORTS - 1);

  stage_state_t r_state;
  stage_state_t w_next_state;

  logic [PAYLOAD_BITS-1:0]                  r_dout;
  logic [NUM_PORT_BITS-1:0]                 r_port;
  logic [PTR_BITS-1:0]                      r_rr_ptr;
  logic [NUM_PORTS-1:0][CREDIT_BITS-1:0]    r_credit;
  logic                                     r_ovf;

  logic [NUM_PORTS-1:0]                     w_eligible;
  logic [PTR_BITS-1:0]                      w_grant;
  logic                                     w_any;
  logic                                     w_loadable;
  logic                                     w_load;
  logic                                     w_bad_port;
  logic [NUM_PORTS-1:0]                     w_over;
  logic [NUM_PORTS-1:0][CREDIT_BITS-1:0]    w_credit_next;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
    assign w_eligible[gi] = vld_user2arb[gi] && (r_credit[gi] != '0);
  end

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_BITS  (PTR_BITS)
  ) u_rr_select (
    .eligible     (w_eligible),
    .rr_ptr       (r_rr_ptr),
    .grant        (w_grant),
    .any_eligible (w_any)
  );

  assign w_loadable = (r_state == ST_EMPTY) || ack_interface2arb;
  // Gating with reset keeps user acks low while the block is held in reset.
  assign w_load     = reset && w_loadable && w_any;

  always_comb begin
    ack_arb2user = '0;
    if (w_load) begin
      ack_arb2user[w_grant] = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_load) begin
      w_next_state = ST_FULL;
    end else if ((r_state == ST_FULL) && ack_interface2arb) begin
      w_next_state = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_user) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Wide sum holds credit + amt without wrap so overflow is visible for the clamp.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_credit
    logic               w_load_hit;
    logic               w_upd_hit;
    logic [CREDIT_BITS:0] w_sum;
    assign w_load_hit = w_load && (w_grant == PTR_BITS'(gi));
    assign w_upd_hit  = credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(gi));
    assign w_sum      = {1'b0, r_credit[gi]}
                      + (w_upd_hit ? {1'b0, credit_upd_amt} : '0)
                      - {{CREDIT_BITS{1'b0}}, w_load_hit};
    assign w_over[gi]        = (w_sum > c_init_ext);
    assign w_credit_next[gi] = w_over[gi] ? c_init : w_sum[CREDIT_BITS-1:0];
  end

  assign w_bad_port = credit_upd_vld && (credit_upd_port >= c_num_ports);

  always_ff @(posedge clk_user) begin
    if (!reset) begin
      r_dout   <= '0;
      r_port   <= '0;
      r_rr_ptr <= '0;
      r_credit <= {NUM_PORTS{c_init}};
      r_ovf    <= 1'b0;
    end else begin
      r_credit <= w_credit_next;
      r_ovf    <= r_ovf || (|w_over) || w_bad_port;
      if (w_load) begin
        r_dout   <= din_leaf_user2arb[w_grant*PAYLOAD_BITS +: PAYLOAD_BITS];
        r_port   <= NUM_PORT_BITS'(w_grant);
        r_rr_ptr <= (w_grant == c_last_port) ? '0 : w_grant + PTR_BITS'(1);
      end
    end
  end

  assign dout_arb2interface = r_dout;
  assign port_arb2interface = r_port;
  assign vld_arb2interface  = (r_state == ST_FULL);
  assign credit_ovf_err     = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_user_port_arbiter.sv
// ============================================================================
// Module : tb_user_port_arbiter
// Desc   : Randomized and directed checks of user_port_arbiter against a
//          behavioural model of the arbitration and credit rules.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_user_port_arbiter;

  logic        clk_user = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] din_leaf_user2arb = '0;
  logic [1:0]  vld_user2arb = '0;
  logic [1:0]  ack_arb2user;
  logic [31:0] dout_arb2interface;
  logic [3:0]  port_arb2interface;
  logic        vld_arb2interface;
  logic        ack_interface2arb = 1'b0;
  logic        credit_upd_vld = 1'b0;
  logic [3:0]  credit_upd_port = '0;
  logic [6:0]  credit_upd_amt = '0;
  logic        credit_ovf_err;

  int checks = 0;
  int errors = 0;

  bit          m_full = 0;
  logic [31:0] m_dout = '0;
  int          m_port = 0;
  int          m_ptr = 0;
  int          m_credit [2] = '{64, 64};
  bit          m_ovf = 0;

  always #5 clk_user = ~clk_user;

  user_port_arbiter dut (
    .clk_user           (clk_user),
    .reset              (reset),
    .din_leaf_user2arb  (din_leaf_user2arb),
    .vld_user2arb       (vld_user2arb),
    .ack_arb2user       (ack_arb2user),
    .dout_arb2interface (dout_arb2interface),
    .port_arb2interface (port_arb2interface),
    .vld_arb2interface  (vld_arb2interface),
    .ack_interface2arb  (ack_interface2arb),
    .credit_upd_vld     (credit_upd_vld),
    .credit_upd_port    (credit_upd_port),
    .credit_upd_amt     (credit_upd_amt),
    .credit_ovf_err     (credit_ovf_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, check acks, then check state after the rise.
  task automatic step(input logic [1:0] v, input logic a, input logic uv,
                      input logic [3:0] up, input logic [6:0] ua,
                      input logic rn, input logic [63:0] din);
    bit          any;
    int          sel;
    logic [1:0]  e_ack;
    vld_user2arb      = v;
    ack_interface2arb = a;
    credit_upd_vld    = uv;
    credit_upd_port   = up;
    credit_upd_amt    = ua;
    reset             = rn;
    din_leaf_user2arb = din;
    any = 0;
    sel = 0;
    e_ack = '0;
    if (rn && (!m_full || a)) begin
      for (int k = 0; k < 2; k++) begin
        int p;
        p = (m_ptr + k) % 2;
        if (!any && v[p] && m_credit[p] > 0) begin
          any = 1;
          sel = p;
        end
      end
    end
    if (any) e_ack[sel] = 1'b1;
    #1;
    check("ack", 64'(ack_arb2user), 64'(e_ack));
    @(posedge clk_user);
    if (!rn) begin
      m_full = 0; m_dout = '0; m_port = 0; m_ptr = 0; m_ovf = 0;
      m_credit[0] = 64; m_credit[1] = 64;
    end else begin
      for (int p = 0; p < 2; p++) begin
        int val;
        val = m_credit[p] - ((any && sel == p) ? 1 : 0) + ((uv && int'(up) == p) ? int'(ua) : 0);
        if (val > 64) begin
          val = 64;
          m_ovf = 1;
        end
        m_credit[p] = val;
      end
      if (uv && up >= 4'd2) m_ovf = 1;
      if (any) begin
        m_full = 1;
        m_dout = din[sel*32 +: 32];
        m_port = sel;
        m_ptr  = (sel + 1) % 2;
      end else if (m_full && a) begin
        m_full = 0;
      end
    end
    #1;
    check("vld", 64'(vld_arb2interface), 64'(m_full));
    check("dout", 64'(dout_arb2interface), 64'(m_dout));
    check("port", 64'(port_arb2interface), 64'(m_port));
    check("ovf", 64'(credit_ovf_err), 64'(m_ovf));
    check("credit0", 64'(dut.r_credit[0]), 64'(m_credit[0]));
    check("credit1", 64'(dut.r_credit[1]), 64'(m_credit[1]));
    @(negedge clk_user);
  endtask

  function automatic logic [63:0] rnd_din();
    return {$urandom, $urandom};
  endfunction

  initial begin
    @(negedge clk_user);
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    check("rst_vld", 64'(vld_arb2interface), 64'd0);
    check("rst_credit1", 64'(dut.r_credit[1]), 64'd64);

    // Both ports streaming with the interface always ready.
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
      check("alt_port", 64'(port_arb2interface), 64'(i % 2));
    end
    check("alt_credit0", 64'(dut.r_credit[0]), 64'd62);
    check("alt_credit1", 64'(dut.r_credit[1]), 64'd62);

    // Back-pressure while holding a known word.
    step(2'b00, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, {32'h0, 32'hA5A5A5A5});
    for (int i = 0; i < 5; i++) begin
      step(2'b11, 1'b0, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
      check("stall_word", 64'(dout_arb2interface), 64'hA5A5A5A5);
      check("stall_ack", 64'(ack_arb2user), 64'd0);
    end
    step(2'b00, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    check("stall_drain", 64'(vld_arb2interface), 64'd0);

    // Credit exhaustion on port 0 and recovery.
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    for (int i = 0; i < 64; i++) step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    check("exhaust_credit0", 64'(dut.r_credit[0]), 64'd0);
    step(2'b01, 1'b1, 1'b1, 4'd0, 7'd3, 1'b1, rnd_din());
    for (int i = 0; i < 4; i++) step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    check("recover_credit0", 64'(dut.r_credit[0]), 64'd0);

    // Same-cycle load and return on port 1 at credit 10.
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    for (int i = 0; i < 54; i++) step(2'b10, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    step(2'b10, 1'b1, 1'b1, 4'd1, 7'd1, 1'b1, rnd_din());
    check("same_cycle_credit1", 64'(dut.r_credit[1]), 64'd10);

    // Clamp and sticky overflow flag.
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    step(2'b00, 1'b1, 1'b1, 4'd0, 7'd5, 1'b1, rnd_din());
    check("clamp_credit0", 64'(dut.r_credit[0]), 64'd64);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    check("ovf_sticky", 64'(credit_ovf_err), 64'd1);

    // Reset while full.
    step(2'b00, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    for (int i = 0; i < 24; i++) step(2'b10, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    step(2'b01, 1'b1, 1'b0, 4'd0, 7'd0, 1'b1, rnd_din());
    check("pre_rst_credit1", 64'(dut.r_credit[1]), 64'd40);
    step(2'b11, 1'b0, 1'b0, 4'd0, 7'd0, 1'b0, rnd_din());
    check("mid_rst_vld", 64'(vld_arb2interface), 64'd0);
    check("mid_rst_credit1", 64'(dut.r_credit[1]), 64'd64);
    check("mid_rst_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Randomized traffic, returns, bad ports and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(2'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 3)), 7'($urandom_range(0, 8)),
           ($urandom_range(0, 199) != 0), rnd_din());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
